uart_tx_fifo_drain: RTL and testbench
=====================================

// Module: uart_tx_fifo_drain
// PURPOSE
//   Consumer (read) side of the fifo block: pops bytes from a show-ahead fifo and
//   serialises each one as a UART 8N1 frame on tx. Sits between the fifo's
//   pop/pop_data/empty outputs and the board TX pin.
//   Frame timing comes from an internal bit-period counter. No external baud tick.
// PARAMETERS
//   CLK_FREQ   100_000_000  system clock frequency, Hz
//   BAUD       9600         line rate, bit/s
//   BIT_WIDTH  8            data bits per frame; equals the fifo data width
//   CLKS_PER_BIT (localparam) = CLK_FREQ/BAUD (integer divide); must be >= 2
// PORTS
//   clk        in   1          system clock, rising edge
//   rst        in   1          synchronous, active-high reset
//   fifo_empty in   1          fifo empty flag
//   fifo_data  in   BIT_WIDTH  fifo pop_data; valid whenever fifo_empty==0 (show-ahead)
//   fifo_pop   out  1          pop strobe to fifo; exactly one cycle per byte taken
//   tx         out  1          serial line, idle high, registered
//   tx_busy    out  1          high while a frame is on the line (START..STOP)
//   tx_done    out  1          one-cycle pulse in the last clk of the STOP bit
// BEHAVIOUR
//   - One clock domain (clk). rst is synchronous and active-high; sampled on posedge clk only.
//   - Reset values: state=IDLE, tx=1, tx_busy=0, tx_done=0, fifo_pop=0,
//     baud counter=0, bit index=0, shift register=0.
//   - FSM states: IDLE, START, DATA, STOP.
//   - IDLE behaviour:
//     - fifo_pop = (state==IDLE) & ~fifo_empty. This is combinational.
//     - At that same edge: shift_reg <= fifo_data, and state goes to START.
//     - The pop is therefore exactly 1 cycle wide, and the byte is captured in the pop cycle.
//     - Later changes on fifo_data have no effect on the frame in flight.
//   - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
//   - DATA:
//     - tx=shift_reg[0], held for CLKS_PER_BIT cycles per bit, LSB first.
//     - After each bit period: shift right and increment the bit index.
//     - After bit BIT_WIDTH-1, go to STOP.
//   - STOP: tx=1 for CLKS_PER_BIT cycles. tx_done=1 in the final cycle. Then go to IDLE.
//   - tx is registered. The line changes one cycle after the state/counter edge that selects it.
//     The first START low appears on the cycle after the fifo_pop cycle.
//   - tx_busy = 1 in START, DATA and STOP; 0 in IDLE.
//   - Baud counter:
//     - Width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1.
//     - Clears at every state change. Never wraps inside a bit.
//   - Frame period: 1 IDLE/pop cycle + (BIT_WIDTH+2)*CLKS_PER_BIT cycles.
//     Back-to-back bytes are separated by exactly one idle-high clk.
//   - fifo_empty is ignored outside IDLE. No pop is ever issued while busy.
//   - fifo_empty=1 in IDLE: no pop, tx stays 1, and the state remains IDLE.
//   - Reset mid-frame: next edge returns to reset values (tx=1, tx_busy=0).
//     The byte in flight is dropped, not re-popped. fifo_pop=0 during rst.
//   - No parity, no break generation, no flow control.
// TESTING  (CLK_FREQ=100, BAUD=10 -> CLKS_PER_BIT=10, BIT_WIDTH=8)
//   1 Reset: rst=1 for 3 clk with fifo_empty=0
//     -> tx=1, fifo_pop=0, tx_busy=0, tx_done=0 throughout.
//   2 Single byte: fifo_data=8'hA5, fifo_empty low
//     -> fifo_pop high for exactly 1 clk.
//     -> tx: 10 clk low, then bits 1,0,1,0,0,1,0,1 at 10 clk each, then 10 clk high.
//     -> tx_done pulses once; tx_busy high for 100 clk.
//   3 Back-to-back: fifo holds 8'h00, 8'hFF, 8'h55
//     -> 3 pops spaced 101 clk apart; 3 correct frames with a 1-clk idle gap between them.
//   4 Empty: fifo_empty=1 for 500 clk -> no pop, tx=1, tx_busy=0.
//   5 Reset mid-frame: rst=1 during DATA bit 3 of 8'hC3, with fifo_empty=1 afterwards
//     -> tx=1 and tx_busy=0 one clk later; no further pop or frame.
//   6 Capture: fifo_data changes from 8'h3C to 8'hFF the clk after the pop
//     -> serialised frame is still 8'h3C.

Source files
------------

// File: rtl/uart_tx_fifo_drain_if.sv
// Fifo read-side handshake between a show-ahead fifo and the UART drain.
// master = drain (issues pop), slave = fifo (presents empty/data).
interface uart_tx_fifo_drain_if #(
    parameter int BIT_WIDTH = 8
);
    logic                 fifo_empty;
    logic [BIT_WIDTH-1:0] fifo_data;
    logic                 fifo_pop;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_pop
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_pop
    );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from a show-ahead fifo and sends each as a UART 8N1 frame on tx.
// state | meaning
// IDLE  | line high; pops and captures a byte whenever the fifo is not empty
// START | start bit (low) for one bit period
// DATA  | data bits LSB first, one bit period each
// STOP  | stop bit (high); tx_done in its last clk
module uart_tx_fifo_drain #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int BIT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_fifo_drain_if.master  fifo,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BIT_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     baud_cnt, baud_cnt_nxt;
    logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
    logic [BIT_WIDTH-1:0] shift_reg, shift_reg_nxt;
    logic                 tx_nxt, tx_busy_nxt, tx_done_nxt;
    logic                 bit_end;

    assign bit_end       = (baud_cnt == CNT_LAST);
    assign fifo.fifo_pop = (state == IDLE) && !fifo.fifo_empty && !rst;

    always_comb begin
        state_nxt     = state;
        baud_cnt_nxt  = baud_cnt;
        bit_idx_nxt   = bit_idx;
        shift_reg_nxt = shift_reg;
        case (state)
            IDLE: begin
                if (!fifo.fifo_empty) begin
                    state_nxt     = START;
                    baud_cnt_nxt  = '0;
                    shift_reg_nxt = fifo.fifo_data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt    = DATA;
                    baud_cnt_nxt = '0;
                    bit_idx_nxt  = '0;
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_nxt  = '0;
                    shift_reg_nxt = shift_reg >> 1;
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt    = IDLE;
                    baud_cnt_nxt = '0;
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are derived from the next state so the registered line lines up with the state.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_reg_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
        tx_busy_nxt = (state_nxt != IDLE);
        tx_done_nxt = (state_nxt == STOP) && (baud_cnt_nxt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_reg <= shift_reg_nxt;
            tx        <= tx_nxt;
            tx_busy   <= tx_busy_nxt;
            tx_done   <= tx_done_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: a queue acts as the fifo, a frame-offset model predicts the outputs.
module tb_uart_tx_fifo_drain;
    localparam int CPB   = 10;
    localparam int BW    = 8;
    localparam int FRAME = (BW + 2) * CPB;
    localparam int LOG_N = 32768;

    logic clk = 1'b0;
    logic rst;
    logic tx, tx_busy, tx_done;

    uart_tx_fifo_drain_if #(.BIT_WIDTH(BW)) ifc ();

    uart_tx_fifo_drain #(
        .CLK_FREQ (100),
        .BAUD     (10),
        .BIT_WIDTH(BW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .fifo   (ifc),
        .tx     (tx),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [BW-1:0] q[$];
    logic [BW-1:0] empty_data = 8'hFF;
    bit          force_empty = 1'b0;
    bit          armed = 1'b0;
    bit          pop_taken = 1'b0;
    int          cyc = 0;
    int          pop_times[$];
    int          last_rst_cyc = -1;
    bit          log_tx   [0:LOG_N-1];
    bit          log_busy [0:LOG_N-1];
    bit          log_done [0:LOG_N-1];

    // Model: whether a frame is on the line, the clk offset inside it, and the byte being sent.
    bit          m_in_frame = 1'b0;
    int          m_k = 0;
    logic [BW-1:0] m_byte = '0;
    bit          e_tx, e_busy, e_done, e_pop;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive();
        ifc.fifo_empty = force_empty || (q.size() == 0);
        ifc.fifo_data  = (q.size() != 0) ? q[0] : empty_data;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            if (pop_taken && q.size() != 0) q.delete(0);
            #1;
            drive();
        end
    endtask

    task automatic wait_pop(input string nm);
        int n0 = pop_times.size();
        int w = 0;
        while (pop_times.size() == n0 && w < 20) begin
            cycles(1);
            w++;
        end
        check(nm, pop_times.size(), n0 + 1);
    endtask

    task automatic frame_lit(input string nm, input int pc, input logic [9:0] pat);
        int nb = 0;
        int nd = 0;
        check({nm, "_idx"}, int'(pc >= 0 && pc + FRAME + 1 < LOG_N), 1);
        if (pc >= 0 && pc + FRAME + 1 < LOG_N) begin
            for (int j = 0; j < 10; j++)
                for (int k = 0; k < CPB; k++)
                    check({nm, "_tx"}, log_tx[pc + 1 + j * CPB + k], pat[j]);
            for (int i = 1; i <= FRAME; i++) nb += log_busy[pc + i];
            for (int i = 0; i <= FRAME + 1; i++) nd += log_done[pc + i];
            check({nm, "_busy_cnt"}, nb, 100);
            check({nm, "_busy_pre"}, log_busy[pc], 0);
            check({nm, "_busy_post"}, log_busy[pc + FRAME + 1], 0);
            check({nm, "_done_cnt"}, nd, 1);
            check({nm, "_done_pos"}, log_done[pc + 100], 1);
            check({nm, "_gap_tx"}, log_tx[pc + 101], 1);
        end
    endtask

    // Per-cycle compare against the model, then advance the model with this cycle's inputs.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            e_busy = m_in_frame;
            e_done = m_in_frame && (m_k == FRAME - 1);
            if (!m_in_frame)              e_tx = 1'b1;
            else if (m_k < CPB)           e_tx = 1'b0;
            else if (m_k < (BW + 1) * CPB) e_tx = m_byte[(m_k - CPB) / CPB];
            else                          e_tx = 1'b1;
            e_pop = !m_in_frame && !ifc.fifo_empty && !rst;

            check("pop", ifc.fifo_pop, e_pop);
            check("tx", tx, e_tx);
            check("busy", tx_busy, e_busy);
            check("done", tx_done, e_done);

            if (cyc < LOG_N) begin
                log_tx[cyc]   = tx;
                log_busy[cyc] = tx_busy;
                log_done[cyc] = tx_done;
            end
            pop_taken = ifc.fifo_pop;
            if (ifc.fifo_pop) pop_times.push_back(cyc);
            if (rst) last_rst_cyc = cyc;

            if (rst) begin
                m_in_frame = 1'b0;
            end else if (m_in_frame) begin
                m_k++;
                if (m_k == FRAME) m_in_frame = 1'b0;
            end else if (!ifc.fifo_empty) begin
                m_in_frame = 1'b1;
                m_k        = 0;
                m_byte     = ifc.fifo_data;
            end
        end
        cyc++;
    end

    initial begin
        int pc;
        int r;
        int nb;
        int g;

        // Reset with a byte already waiting, then a single A5 frame.
        rst = 1'b1;
        q.push_back(8'hA5);
        drive();
        cycles(1);
        armed = 1'b1;
        cycles(2);
        check("rst_no_pop", pop_times.size(), 0);
        rst = 1'b0;
        cycles(105);
        check("t2_pops", pop_times.size(), 1);
        frame_lit("t2", pop_times[0], 10'b1_10100101_0);

        // Back-to-back bytes.
        q.push_back(8'h00);
        q.push_back(8'hFF);
        q.push_back(8'h55);
        cycles(330);
        check("t3_pops", pop_times.size(), 4);
        check("t3_gap1", pop_times[2] - pop_times[1], 101);
        check("t3_gap2", pop_times[3] - pop_times[2], 101);
        frame_lit("t3a", pop_times[1], 10'b1_00000000_0);
        frame_lit("t3b", pop_times[2], 10'b1_11111111_0);
        frame_lit("t3c", pop_times[3], 10'b1_01010101_0);

        // Empty fifo: line stays idle.
        cycles(500);
        check("t4_pops", pop_times.size(), 4);
        nb = 0;
        for (int i = cyc - 490; i < cyc; i++) nb += log_busy[i];
        check("t4_busy_cnt", nb, 0);

        // Reset in the middle of data bit 3 of C3.
        q.push_back(8'hC3);
        wait_pop("t5_pop");
        pc = pop_times[pop_times.size() - 1];
        while (cyc < pc + 46) cycles(1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(150);
        r = last_rst_cyc;
        check("t5_busy_in_rst", log_busy[r], 1);
        check("t5_tx_bit3", log_tx[r], 0);
        check("t5_tx_after", log_tx[r + 1], 1);
        check("t5_busy_after", log_busy[r + 1], 0);
        check("t5_pops", pop_times.size(), 5);

        // Data bus changes right after the pop.
        empty_data = 8'hFF;
        q.push_back(8'h3C);
        wait_pop("t6_pop");
        pc = pop_times[pop_times.size() - 1];
        cycles(110);
        frame_lit("t6", pc, 10'b1_00111100_0);
        check("t6_pops", pop_times.size(), 6);

        // Randomised traffic, stalls and resets.
        for (int it = 0; it < 30; it++) begin
            int np;
            np = $urandom_range(0, 3);
            for (int b = 0; b < np; b++) q.push_back(8'($urandom));
            empty_data  = 8'($urandom);
            force_empty = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                cycles($urandom_range(1, 3));
                rst = 1'b0;
            end
            cycles($urandom_range(1, 250));
        end
        force_empty = 1'b0;
        g = 0;
        while (q.size() != 0 && g < 12000) begin
            cycles(1);
            g++;
        end
        check("drain_empty", q.size(), 0);
        cycles(110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
